delay_tap_reader: RTL

- RAM-backed circular delay line with a programmable read tap, clocked per audio sample strobe.
- Consumer-side counterpart to the comb filter's fixed shift-register delay: the comb, allpass and reverb stages write a sample and read back the sample written `delay` strobes earlier.
- Memory is block-RAM friendly: one write port, one synchronous read port.
- After reset the block zero-fills its RAM so filters start from silence.

---
 rtl/delay_tap_reader_pkg.sv | 13 +
 rtl/delay_tap_reader_ram.sv | 41 ++++
 rtl/delay_tap_reader.sv | 105 ++++++++++
 3 files changed

// File: rtl/delay_tap_reader_pkg.sv
// rtl/delay_tap_reader_pkg.sv - shared audio constants and delay-line state encoding
package delay_tap_reader_pkg;

    localparam int SAMPLE_WIDTH      = 12;
    localparam int DEFAULT_DELAY_LEN = 2048;

    // CLEAR: zero-fill sweep after reset; RUN: normal strobe-driven operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/delay_tap_reader_ram.sv
// rtl/delay_tap_reader_ram.sv - simple dual-port RAM, one sync write port, one sync read port
//
// Ports:
//   clk    system clock
//   reset  sync active-high; clears only the read-data register, never the array
//   we     write enable; waddr/wdata written on the clock edge
//   re     read enable; rdata <= mem[raddr] on the clock edge, otherwise rdata holds
module delay_ram #(
    parameter int WIDTH = 12,
    parameter int LEN   = 2048,
    localparam int ADDR_W = $clog2(LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the block's output register, so it gets a
    // reset and holds its value between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/delay_tap_reader.sv
// rtl/delay_tap_reader.sv - RAM-backed circular delay line with a programmable read tap
//
// Ports:
//   clk        system clock
//   reset      sync active-high; restarts the RAM clear sweep
//   enable     sample strobe, one cycle per audio sample (ignored while busy)
//   in         sample written on enable
//   delay      tap distance in samples, sampled on enable (0 behaves as 1)
//   out        delayed sample, registered, holds between strobes
//   out_valid  one-cycle pulse the cycle after each accepted strobe
//   busy       high during the post-reset zero-fill sweep
module delay_tap_reader
    import delay_tap_reader_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH,
    parameter int LEN   = DEFAULT_DELAY_LEN,
    localparam int ADDR_W = $clog2(LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] delay,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] d_eff;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WIDTH-1:0]  ram_wdata;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;

    // A zero tap would read the address being written; force at least one
    // sample of delay so the read port never collides with the write port.
    assign d_eff = (delay == '0) ? ADDR_W'(1) : delay;

    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = in;
        ram_re    = 1'b0;
        ram_raddr = wr_ptr - d_eff;   // natural ADDR_W wrap gives mod LEN
        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr;
                ram_wdata = '0;
                if (clr_ptr == ADDR_W'(LEN - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (enable) begin
                    ram_we = 1'b1;
                    ram_re = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr   <= '0;
            wr_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= ram_re;
            if (state_q == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (ram_re) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    assign busy = (state_q == CLEAR);

    delay_ram #(
        .WIDTH (WIDTH),
        .LEN   (LEN)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (out)
    );

endmodule
